// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: decode request -> alu handshake -> writeback.
// Optional EXEC watchdog enabled by defining ALU_TIMEOUT_EN.
module alu_issue_ctrl #(
   parameter int WIDTH          = 32,
   parameter int TAG_W          = 5,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             CK_REF,
   input  logic             RST_N,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [3:0]       REQ_OP,
   input  logic [WIDTH-1:0] REQ_A,
   input  logic [WIDTH-1:0] REQ_B,
   input  logic [TAG_W-1:0] REQ_TAG,
   output logic             ALU_EN,
   output logic [3:0]       OP_VAL,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] OUT,
   input  logic             CARRY_FLAG,
   input  logic             ZERO_FLAG,
   input  logic             OVERFLOW_FLAG,
   input  logic             ALU_DONE,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [WIDTH-1:0] RES_DATA,
   output logic [2:0]       RES_FLAGS,
   output logic [TAG_W-1:0] RES_TAG,
   output logic             RES_ERR,
   output logic             BUSY
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic             res_hs;
   logic             accept;
   logic             timeout;
   logic             finish;
   logic [TAG_W-1:0] tag_q;

   assign res_hs    = (state == RESP) & RES_READY;
   assign REQ_READY = RST_N & ((state == IDLE) | res_hs);
   assign accept    = REQ_VALID & REQ_READY;
   assign finish    = (state == EXEC) & (ALU_DONE | timeout);
   assign BUSY      = (state != IDLE);

`ifdef ALU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] exec_cnt;

   // ALU_DONE on the expiry edge wins, so timeout is qualified by ~ALU_DONE
   assign timeout = (state == EXEC) & ~ALU_DONE
                  & (exec_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CK_REF) begin
      if (!RST_N || accept)
         exec_cnt <= '0;
      else if (state == EXEC)
         exec_cnt <= exec_cnt + 1'b1;
   end

   always_ff @(posedge CK_REF) begin
      if (!RST_N)
         RES_ERR <= 1'b0;
      else if (finish)
         RES_ERR <= ~ALU_DONE;
   end
`else
   logic timeout_unused;

   assign timeout        = 1'b0;
   assign timeout_unused = (TIMEOUT_CYCLES == 0);
   assign RES_ERR        = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = EXEC;
         EXEC: if (finish) state_nxt = RESP;
         RESP: if (res_hs) state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CK_REF) begin
      if (!RST_N) begin
         state     <= IDLE;
         ALU_EN    <= 1'b0;
         RES_VALID <= 1'b0;
         OP_VAL    <= '0;
         A         <= '0;
         B         <= '0;
         tag_q     <= '0;
         RES_DATA  <= '0;
         RES_FLAGS <= '0;
         RES_TAG   <= '0;
      end else begin
         state     <= state_nxt;
         ALU_EN    <= (state_nxt == EXEC);
         RES_VALID <= (state_nxt == RESP);
         if (accept) begin
            OP_VAL <= REQ_OP;
            A      <= REQ_A;
            B      <= REQ_B;
            tag_q  <= REQ_TAG;
         end
         // a timed-out op reports zero data and flags
         if (finish) begin
            RES_DATA  <= ALU_DONE ? OUT : '0;
            RES_FLAGS <= ALU_DONE ?
                         {OVERFLOW_FLAG, CARRY_FLAG, ZERO_FLAG} : 3'b000;
            RES_TAG   <= tag_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural alu and
// a queue-based reference model of the request/result stream.
module tb_alu_issue_ctrl;

   localparam int WIDTH = 32;
   localparam int TAG_W = 5;
   localparam int TO    = 16;

   logic             CK_REF    = 1'b0;
   logic             RST_N     = 1'b0;
   logic             REQ_VALID = 1'b0;
   logic             REQ_READY;
   logic [3:0]       REQ_OP    = '0;
   logic [WIDTH-1:0] REQ_A     = '0;
   logic [WIDTH-1:0] REQ_B     = '0;
   logic [TAG_W-1:0] REQ_TAG   = '0;
   logic             ALU_EN;
   logic [3:0]       OP_VAL;
   logic [WIDTH-1:0] A, B, OUT;
   logic             CARRY_FLAG, ZERO_FLAG, OVERFLOW_FLAG, ALU_DONE;
   logic             RES_VALID;
   logic             RES_READY = 1'b0;
   logic [WIDTH-1:0] RES_DATA;
   logic [2:0]       RES_FLAGS;
   logic [TAG_W-1:0] RES_TAG;
   logic             RES_ERR, BUSY;

   int checks = 0;
   int errors = 0;

   alu_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
      .CK_REF(CK_REF), .RST_N(RST_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_TAG(REQ_TAG),
      .ALU_EN(ALU_EN), .OP_VAL(OP_VAL), .A(A), .B(B),
      .OUT(OUT), .CARRY_FLAG(CARRY_FLAG), .ZERO_FLAG(ZERO_FLAG),
      .OVERFLOW_FLAG(OVERFLOW_FLAG), .ALU_DONE(ALU_DONE),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_DATA(RES_DATA), .RES_FLAGS(RES_FLAGS), .RES_TAG(RES_TAG),
      .RES_ERR(RES_ERR), .BUSY(BUSY)
   );

   always #5 CK_REF = ~CK_REF;

   // behavioural alu: {overflow, carry, zero, result}
   function automatic logic [34:0] alu_fn(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic c, v;
      s = '0;
      case (op)
         4'd1: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd2: begin
            s = {1'b0, a} - {1'b0, b};
            r = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         default: begin
            r = a & b; c = 1'b0; v = 1'b0;
         end
      endcase
      return {v, c, (r == 32'd0), r};
   endfunction

   int          alu_lat   = 0;
   bit          alu_stuck = 1'b0;
   int          en_cnt    = 0;
   logic [34:0] alu_res;

   always @(posedge CK_REF) en_cnt <= ALU_EN ? en_cnt + 1 : 0;

   assign alu_res       = alu_fn(OP_VAL, A, B);
   assign OUT           = alu_res[31:0];
   assign ZERO_FLAG     = alu_res[32];
   assign CARRY_FLAG    = alu_res[33];
   assign OVERFLOW_FLAG = alu_res[34];
   assign ALU_DONE      = ALU_EN && !alu_stuck && (en_cnt >= alu_lat);

   typedef struct {
      logic [31:0] d;
      logic [2:0]  f;
      logic [4:0]  t;
      int          rdy;
   } exp_t;

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (2) @(negedge CK_REF);
      #1;
      checks++;
      if (REQ_READY !== 1'b0 || ALU_EN !== 1'b0 || RES_VALID !== 1'b0 ||
          BUSY !== 1'b0 || RES_ERR !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: rdy=%b en=%b vld=%b busy=%b err=%b required 00000",
                  REQ_READY, ALU_EN, RES_VALID, BUSY, RES_ERR);
      end
      checks++;
      if (OP_VAL !== 4'd0 || A !== 32'd0 || B !== 32'd0 || RES_DATA !== 32'd0 ||
          RES_FLAGS !== 3'd0 || RES_TAG !== 5'd0) begin
         errors++;
         $display("FAIL reset_regs: op=%h a=%h b=%h d=%h f=%b t=%h required all 0",
                  OP_VAL, A, B, RES_DATA, RES_FLAGS, RES_TAG);
      end
      RST_N = 1'b1;
      #1;
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b required 1", REQ_READY);
      end
   endtask

   // one isolated op from IDLE with RES_READY=1
   task automatic run_op(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int lat,
                         input logic [31:0] exp_d, input logic [2:0] exp_f);
      @(negedge CK_REF);
      REQ_VALID = 1'b1; REQ_OP = op; REQ_A = a; REQ_B = b; REQ_TAG = tag;
      RES_READY = 1'b1; alu_lat = lat;
      #1;
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready: got %b required 1", nm, REQ_READY);
      end
      for (int i = 0; i <= lat; i++) begin
         @(negedge CK_REF);
         REQ_VALID = 1'b0;
         #1;
         checks++;
         if (ALU_EN !== 1'b1 || RES_VALID !== 1'b0 || OP_VAL !== op ||
             A !== a || B !== b) begin
            errors++;
            $display("FAIL %s_exec%0d: en=%b vld=%b op=%h a=%h b=%h required 1 0 %h %h %h",
                     nm, i, ALU_EN, RES_VALID, OP_VAL, A, B, op, a, b);
         end
      end
      @(negedge CK_REF);
      #1;
      checks++;
      if (RES_VALID !== 1'b1 || ALU_EN !== 1'b0 || RES_ERR !== 1'b0) begin
         errors++;
         $display("FAIL %s_resp: vld=%b en=%b err=%b required 1 0 0",
                  nm, RES_VALID, ALU_EN, RES_ERR);
      end
      checks++;
      if (RES_DATA !== exp_d || RES_FLAGS !== exp_f || RES_TAG !== tag) begin
         errors++;
         $display("FAIL %s_result: d=%0d f=%b t=%0d required %0d %b %0d",
                  nm, RES_DATA, RES_FLAGS, RES_TAG, exp_d, exp_f, tag);
      end
      @(negedge CK_REF);
      #1;
      checks++;
      if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || RES_DATA !== exp_d ||
          A !== a || RES_TAG !== tag) begin
         errors++;
         $display("FAIL %s_hold: vld=%b busy=%b d=%0d a=%h t=%0d required 0 0 %0d %h %0d",
                  nm, RES_VALID, BUSY, RES_DATA, A, RES_TAG, exp_d, a, tag);
      end
   endtask

   task automatic test_single_add();
      run_op("add", 4'b0001, 32'd5, 32'd6, 5'd3, 0, 32'd11, 3'b000);
      run_op("add_slow", 4'b0001, 32'd5, 32'd6, 5'd3, 2, 32'd11, 3'b000);
   endtask

   task automatic test_carry_zero();
      run_op("carry", 4'b0001, 32'hFFFF_FFFF, 32'd1, 5'd9, 0, 32'd0, 3'b011);
      run_op("nocarry", 4'b0001, 32'd9000, 32'd8192, 5'd4, 1, 32'd17192, 3'b000);
   endtask

   task automatic test_stall();
      @(negedge CK_REF);
      alu_lat = 0; RES_READY = 1'b0;
      REQ_VALID = 1'b1; REQ_OP = 4'd1; REQ_A = 32'd15; REQ_B = 32'd100;
      REQ_TAG = 5'd7;
      #1;
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL stall_first_ready: got %b required 1", REQ_READY);
      end
      @(negedge CK_REF);
      REQ_A = 32'd1; REQ_B = 32'd2; REQ_TAG = 5'd8;
      #1;
      checks++;
      if (ALU_EN !== 1'b1 || REQ_READY !== 1'b0) begin
         errors++;
         $display("FAIL stall_exec: en=%b rdy=%b required 1 0", ALU_EN, REQ_READY);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge CK_REF);
         #1;
         checks++;
         if (RES_VALID !== 1'b1 || RES_DATA !== 32'd115 || RES_TAG !== 5'd7 ||
             REQ_READY !== 1'b0 || ALU_EN !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: vld=%b d=%0d t=%0d rdy=%b en=%b required 1 115 7 0 0",
                     i, RES_VALID, RES_DATA, RES_TAG, REQ_READY, ALU_EN);
         end
      end
      @(negedge CK_REF);
      RES_READY = 1'b1;
      #1;
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL stall_release_ready: got %b required 1", REQ_READY);
      end
      @(negedge CK_REF);
      REQ_VALID = 1'b0;
      #1;
      checks++;
      if (ALU_EN !== 1'b1 || RES_VALID !== 1'b0 || A !== 32'd1 ||
          RES_DATA !== 32'd115) begin
         errors++;
         $display("FAIL stall_next_exec: en=%b vld=%b a=%0d d=%0d required 1 0 1 115",
                  ALU_EN, RES_VALID, A, RES_DATA);
      end
      @(negedge CK_REF);
      #1;
      checks++;
      if (RES_VALID !== 1'b1 || RES_DATA !== 32'd3 || RES_TAG !== 5'd8) begin
         errors++;
         $display("FAIL stall_next_result: vld=%b d=%0d t=%0d required 1 3 8",
                  RES_VALID, RES_DATA, RES_TAG);
      end
      @(negedge CK_REF);
      #1;
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL stall_idle: busy=%b required 0", BUSY);
      end
   endtask

   // streamed traffic against a queue of expected results and ready times
   task automatic run_stream(input string nm, input int n, input int pv,
                             input int pr, input int maxlat, input bit b2b);
      exp_t        q[$];
      exp_t        e;
      logic [34:0] r;
      int          sent = 0;
      int          cyc = 0;
      int          last_res = -1;
      int          lat;
      bit          ev, er, acc;
      acc = 1'b0;
      REQ_VALID = 1'b0;
      while ((sent < n || q.size() > 0) && cyc < 1000) begin
         @(negedge CK_REF);
         if (acc) REQ_VALID = 1'b0;
         acc = 1'b0;
         if (!REQ_VALID && sent < n && $urandom_range(99) < pv) begin
            REQ_VALID = 1'b1;
            REQ_OP    = 4'($urandom_range(3));
            REQ_A     = $urandom;
            REQ_B     = $urandom;
            REQ_TAG   = b2b ? TAG_W'(sent) : TAG_W'($urandom);
         end
         RES_READY = ($urandom_range(99) < pr);
         #1;
         ev = (q.size() > 0) && (cyc >= q[0].rdy);
         er = (q.size() == 0) || (ev && RES_READY);
         checks++;
         if (RES_VALID !== ev || REQ_READY !== er || BUSY !== (q.size() > 0) ||
             ALU_EN !== ((q.size() > 0) && !ev)) begin
            errors++;
            $display("FAIL %s_ctrl@%0d: vld=%b rdy=%b busy=%b en=%b required %b %b %b %b",
                     nm, cyc, RES_VALID, REQ_READY, BUSY, ALU_EN,
                     ev, er, q.size() > 0, (q.size() > 0) && !ev);
         end
         if (ev) begin
            checks++;
            if (RES_DATA !== q[0].d || RES_FLAGS !== q[0].f ||
                RES_TAG !== q[0].t || RES_ERR !== 1'b0) begin
               errors++;
               $display("FAIL %s_data@%0d: d=%h f=%b t=%0d err=%b required %h %b %0d 0",
                        nm, cyc, RES_DATA, RES_FLAGS, RES_TAG, RES_ERR,
                        q[0].d, q[0].f, q[0].t);
            end
            if (RES_READY) begin
               if (b2b && last_res >= 0) begin
                  checks++;
                  if (cyc - last_res != 2) begin
                     errors++;
                     $display("FAIL %s_spacing: got %0d cycles required 2",
                              nm, cyc - last_res);
                  end
               end
               last_res = cyc;
               void'(q.pop_front());
            end
         end
         if (REQ_VALID && er) begin
            lat     = $urandom_range(maxlat, 0);
            alu_lat = lat;
            r       = alu_fn(REQ_OP, REQ_A, REQ_B);
            e.d     = r[31:0];
            e.f     = {r[34], r[33], r[32]};
            e.t     = REQ_TAG;
            e.rdy   = cyc + 2 + lat;
            q.push_back(e);
            sent++;
            acc = 1'b1;
         end
         cyc++;
      end
      @(negedge CK_REF);
      if (acc) REQ_VALID = 1'b0;
      checks++;
      if (sent != n || q.size() != 0) begin
         errors++;
         $display("FAIL %s_complete: sent=%0d pending=%0d required %0d 0",
                  nm, sent, q.size(), n);
      end
   endtask

   task automatic test_back_to_back();
      run_stream("b2b", 4, 100, 100, 0, 1'b1);
   endtask

   task automatic test_random();
      run_stream("rand", 40, 60, 60, 3, 1'b0);
   endtask

   task automatic test_reset_mid_exec();
      @(negedge CK_REF);
      alu_stuck = 1'b1; RES_READY = 1'b1;
      REQ_VALID = 1'b1; REQ_OP = 4'd1; REQ_A = 32'd7; REQ_B = 32'd9;
      REQ_TAG = 5'd5;
      @(negedge CK_REF);
      REQ_VALID = 1'b0;
      @(negedge CK_REF);
      #1;
      checks++;
      if (ALU_EN !== 1'b1 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec_pre: en=%b busy=%b required 1 1", ALU_EN, BUSY);
      end
      RST_N = 1'b0;
      @(negedge CK_REF);
      #1;
      checks++;
      if (ALU_EN !== 1'b0 || RES_VALID !== 1'b0 || BUSY !== 1'b0 ||
          RES_ERR !== 1'b0 || REQ_READY !== 1'b0) begin
         errors++;
         $display("FAIL rst_exec_ctrl: en=%b vld=%b busy=%b err=%b rdy=%b required 00000",
                  ALU_EN, RES_VALID, BUSY, RES_ERR, REQ_READY);
      end
      checks++;
      if (OP_VAL !== 4'd0 || A !== 32'd0 || B !== 32'd0 || RES_DATA !== 32'd0 ||
          RES_FLAGS !== 3'd0 || RES_TAG !== 5'd0) begin
         errors++;
         $display("FAIL rst_exec_regs: op=%h a=%h b=%h d=%h f=%b t=%h required all 0",
                  OP_VAL, A, B, RES_DATA, RES_FLAGS, RES_TAG);
      end
      RST_N = 1'b1; alu_stuck = 1'b0;
      #1;
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec_release: rdy=%b required 1", REQ_READY);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge CK_REF);
         #1;
         checks++;
         if (RES_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec_no_result%0d: vld=%b busy=%b required 0 0",
                     i, RES_VALID, BUSY);
         end
      end
   endtask

   task automatic test_stuck_done();
      @(negedge CK_REF);
      alu_stuck = 1'b1; RES_READY = 1'b1;
      REQ_VALID = 1'b1; REQ_OP = 4'd1; REQ_A = 32'd3; REQ_B = 32'd4;
      REQ_TAG = 5'd21;
`ifdef ALU_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         @(negedge CK_REF);
         REQ_VALID = 1'b0;
         #1;
         checks++;
         if (ALU_EN !== 1'b1 || RES_VALID !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait%0d: en=%b vld=%b required 1 0",
                     i, ALU_EN, RES_VALID);
         end
      end
      @(negedge CK_REF);
      #1;
      checks++;
      if (RES_VALID !== 1'b1 || RES_ERR !== 1'b1 || RES_DATA !== 32'd0 ||
          RES_FLAGS !== 3'd0 || RES_TAG !== 5'd21 || ALU_EN !== 1'b0) begin
         errors++;
         $display("FAIL timeout_result: vld=%b err=%b d=%0d f=%b t=%0d en=%b required 1 1 0 000 21 0",
                  RES_VALID, RES_ERR, RES_DATA, RES_FLAGS, RES_TAG, ALU_EN);
      end
      @(negedge CK_REF);
      alu_stuck = 1'b0;
      run_op("done_at_limit", 4'd1, 32'd40, 32'd2, 5'd6, TO - 1, 32'd42, 3'b000);
`else
      for (int i = 0; i < 100; i++) begin
         @(negedge CK_REF);
         REQ_VALID = 1'b0;
         #1;
         checks++;
         if (BUSY !== 1'b1 || RES_VALID !== 1'b0 || RES_ERR !== 1'b0) begin
            errors++;
            $display("FAIL stuck_wait%0d: busy=%b vld=%b err=%b required 1 0 0",
                     i, BUSY, RES_VALID, RES_ERR);
         end
      end
      RST_N = 1'b0;
      @(negedge CK_REF);
      RST_N = 1'b1; alu_stuck = 1'b0;
      #1;
      checks++;
      if (BUSY !== 1'b0 || REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL stuck_recover: busy=%b rdy=%b required 0 1", BUSY, REQ_READY);
      end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_add();
      test_carry_zero();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_mid_exec();
      test_stuck_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
